// File: rtl/vga_timing_if.sv
// Raster timing bundle from vga_timing to the pixel colour stage.
// The producer drives every signal; consumers sample on pix_tick or every clk.
interface vga_timing_if;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       bright;
    logic       hsync;
    logic       vsync;
    logic       pix_tick;
    logic       frame_start;

    modport master (
        output hcount, vcount, bright, hsync, vsync, pix_tick, frame_start
    );

    modport slave (
        input hcount, vcount, bright, hsync, vsync, pix_tick, frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// 640x480@60 raster timing generator: pixel-rate prescaler, h/v counters and
// registered decodes that always describe the counter values they accompany.
module vga_timing #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_timing_if.master vga
);
    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_hcount;
    logic [9:0]       r_vcount;
    logic             r_bright;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_pix_tick;
    logic             r_frame_start;

    logic             w_adv;
    logic             w_h_wrap;
    logic [9:0]       w_h_next;
    logic [9:0]       w_v_next;
    logic             w_bright_next;
    logic             w_hsync_next;
    logic             w_vsync_next;
    logic             w_frame_start_next;

    assign w_adv = (r_div == DIV_LAST);

    // Decodes are computed from the next counter values so they land together.
    always_comb begin
        w_h_wrap = (r_hcount == H_LAST);
        w_h_next = w_h_wrap ? 10'd0 : (r_hcount + 10'd1);
        w_v_next = r_vcount;
        if (w_h_wrap) begin
            w_v_next = (r_vcount == V_LAST) ? 10'd0 : (r_vcount + 10'd1);
        end
        w_bright_next      = (w_h_next < H_VIS) && (w_v_next < V_VIS);
        w_hsync_next       = !((w_h_next >= HS_FIRST) && (w_h_next <= HS_LAST));
        w_vsync_next       = !((w_v_next >= VS_FIRST) && (w_v_next <= VS_LAST));
        w_frame_start_next = (w_h_next == 10'd0) && (w_v_next == 10'd0);
    end

    // Reset parks the raster on the last blanked pixel so the first advance lands on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div         <= '0;
            r_hcount      <= H_LAST;
            r_vcount      <= V_LAST;
            r_bright      <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_pix_tick    <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (w_adv) begin
            r_div         <= '0;
            r_hcount      <= w_h_next;
            r_vcount      <= w_v_next;
            r_bright      <= w_bright_next;
            r_hsync       <= w_hsync_next;
            r_vsync       <= w_vsync_next;
            r_pix_tick    <= 1'b1;
            r_frame_start <= w_frame_start_next;
        end else begin
            r_div         <= r_div + DIV_W'(1);
            r_pix_tick    <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign vga.hcount      = r_hcount;
    assign vga.vcount      = r_vcount;
    assign vga.bright      = r_bright;
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.pix_tick    = r_pix_tick;
    assign vga.frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default build, a CLK_DIV=1 build and a shrunken
// raster (CLK_DIV=3) that makes whole-frame behaviour cheap to observe.
module tb_vga_timing;
    localparam int S_DIV = 3;
    localparam int S_HV = 16, S_HFP = 2, S_HS = 3, S_HBP = 2;
    localparam int S_VV = 10, S_VFP = 2, S_VS = 2, S_VBP = 3;
    localparam int S_HT = S_HV + S_HFP + S_HS + S_HBP;   // 23
    localparam int S_VT = S_VV + S_VFP + S_VS + S_VBP;   // 17
    localparam int S_FRAME = S_HT * S_VT * S_DIV;        // 1173

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_timing_if d_if ();
    vga_timing_if s_if ();
    vga_timing_if o_if ();

    vga_timing u_dut (.clk(clk), .rst_n(rst_n), .vga(d_if));

    vga_timing #(
        .CLK_DIV(S_DIV),
        .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
    ) u_sml (.clk(clk), .rst_n(rst_n), .vga(s_if));

    vga_timing #(.CLK_DIV(1)) u_d1 (.clk(clk), .rst_n(rst_n), .vga(o_if));

    int n_vec = 0;
    int n_err = 0;
    logic [24:0] exp_q[$];

    // Geometry table indexed by build: 0 = default, 1 = small, 2 = CLK_DIV=1.
    int g_div[3] = '{2, S_DIV, 1};
    int g_hv[3]  = '{640, S_HV, 640};
    int g_hfp[3] = '{16, S_HFP, 16};
    int g_hs[3]  = '{96, S_HS, 96};
    int g_ht[3]  = '{800, S_HT, 800};
    int g_vv[3]  = '{480, S_VV, 480};
    int g_vfp[3] = '{10, S_VFP, 10};
    int g_vs[3]  = '{2, S_VS, 2};
    int g_vt[3]  = '{525, S_VT, 525};

    int m_div, m_h, m_v;
    bit m_tick;

    function automatic logic [24:0] sample(input int w);
        case (w)
            0: return {d_if.hcount, d_if.vcount, d_if.bright, d_if.hsync, d_if.vsync,
                       d_if.pix_tick, d_if.frame_start};
            1: return {s_if.hcount, s_if.vcount, s_if.bright, s_if.hsync, s_if.vsync,
                       s_if.pix_tick, s_if.frame_start};
            default: return {o_if.hcount, o_if.vcount, o_if.bright, o_if.hsync, o_if.vsync,
                             o_if.pix_tick, o_if.frame_start};
        endcase
    endfunction

    function automatic void model_init(input int w);
        m_div  = 0;
        m_h    = g_ht[w] - 1;
        m_v    = g_vt[w] - 1;
        m_tick = 1'b0;
    endfunction

    function automatic void model_step(input int w);
        if (m_div == g_div[w] - 1) begin
            m_div  = 0;
            m_tick = 1'b1;
            if (m_h == g_ht[w] - 1) begin
                m_h = 0;
                m_v = (m_v == g_vt[w] - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end else begin
            m_div  = m_div + 1;
            m_tick = 1'b0;
        end
    endfunction

    function automatic logic [24:0] model_out(input int w);
        logic b, hs, vs, fs;
        int hs0, vs0;
        hs0 = g_hv[w] + g_hfp[w];
        vs0 = g_vv[w] + g_vfp[w];
        b  = (m_h < g_hv[w]) && (m_v < g_vv[w]);
        hs = !((m_h >= hs0) && (m_h < hs0 + g_hs[w]));
        vs = !((m_v >= vs0) && (m_v < vs0 + g_vs[w]));
        fs = m_tick && (m_h == 0) && (m_v == 0);
        return {10'(m_h), 10'(m_v), b, hs, vs, m_tick, fs};
    endfunction

    task automatic hold_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard: expected tuple queued at each edge, popped when the DUT is sampled.
    task automatic sb_run(input int w, input int n_clk, input string tag);
        logic [24:0] got, exp;
        int bad;
        bad = 0;
        for (int i = 1; i <= n_clk; i++) begin
            @(posedge clk);
            model_step(w);
            exp_q.push_back(model_out(w));
            @(negedge clk);
            got = sample(w);
            exp = exp_q.pop_front();
            n_vec++;
            if (got !== exp) begin
                n_err++;
                bad++;
                $display("FAIL %s clk=%0d got h=%0d v=%0d flags=%05b exp h=%0d v=%0d flags=%05b",
                         tag, i, got[24:15], got[14:5], got[4:0], exp[24:15], exp[14:5], exp[4:0]);
                if (bad >= 20) break;
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [24:0] got;
        hold_reset();
        got = sample(0);
        n_vec++;
        if (got !== {10'd799, 10'd524, 5'b01100}) begin
            n_err++;
            $display("FAIL reset_default got=%h exp=%h", got, {10'd799, 10'd524, 5'b01100});
        end
        got = sample(1);
        n_vec++;
        if (got !== {10'd22, 10'd16, 5'b01100}) begin
            n_err++;
            $display("FAIL reset_small got=%h exp=%h", got, {10'd22, 10'd16, 5'b01100});
        end
        got = sample(2);
        n_vec++;
        if (got !== {10'd799, 10'd524, 5'b01100}) begin
            n_err++;
            $display("FAIL reset_div1 got=%h exp=%h", got, {10'd799, 10'd524, 5'b01100});
        end
    endtask

    task automatic test_first_edges();
        int eh, ev;
        logic eb, ept, efs;
        hold_reset();
        release_reset();
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            eh  = (i < 2) ? 799 : (i / 2 - 1);
            ev  = (i < 2) ? 524 : 0;
            eb  = (i >= 2);
            ept = (i % 2 == 0);
            efs = (i == 2);
            n_vec++;
            if (d_if.hcount !== 10'(eh) || d_if.vcount !== 10'(ev) || d_if.bright !== eb ||
                d_if.pix_tick !== ept || d_if.frame_start !== efs ||
                d_if.hsync !== 1'b1 || d_if.vsync !== 1'b1) begin
                n_err++;
                $display("FAIL first_edges clk=%0d got h=%0d v=%0d b=%b pt=%b fs=%b exp h=%0d v=%0d b=%b pt=%b fs=%b",
                         i, d_if.hcount, d_if.vcount, d_if.bright, d_if.pix_tick, d_if.frame_start,
                         eh, ev, eb, ept, efs);
            end
        end
    endtask

    task automatic test_scoreboard_default();
        hold_reset();
        release_reset();
        model_init(0);
        sb_run(0, 3300, "sb_default");
    endtask

    task automatic test_hsweep();
        logic pb, phs;
        int ph, pv, t_fall, t_rise, fs_n;
        bit got_bfall, got_vinc;
        hold_reset();
        release_reset();
        pb = 1'b0; phs = 1'b1; ph = 799; pv = 524;
        t_fall = -1; t_rise = -1; fs_n = 0;
        got_bfall = 0; got_vinc = 0;
        for (int i = 1; i <= 3300; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (d_if.pix_tick !== 1'(i % 2 == 0)) begin
                n_err++;
                $display("FAIL pix_tick clk=%0d got=%b exp=%b", i, d_if.pix_tick, 1'(i % 2 == 0));
            end
            if (d_if.frame_start === 1'b1) fs_n++;
            if (pb && !d_if.bright && !got_bfall) begin
                got_bfall = 1;
                n_vec++;
                if (d_if.hcount !== 10'd640 || d_if.vcount !== 10'd0) begin
                    n_err++;
                    $display("FAIL bright_fall got h=%0d v=%0d exp h=640 v=0", d_if.hcount, d_if.vcount);
                end
            end
            if (phs && !d_if.hsync && t_fall < 0) begin
                t_fall = i;
                n_vec++;
                if (d_if.hcount !== 10'd656) begin
                    n_err++;
                    $display("FAIL hsync_fall got h=%0d exp h=656", d_if.hcount);
                end
            end
            if (!phs && d_if.hsync && t_rise < 0) begin
                t_rise = i;
                n_vec++;
                if (d_if.hcount !== 10'd752 || (t_rise - t_fall) != 192) begin
                    n_err++;
                    $display("FAIL hsync_rise got h=%0d width=%0d exp h=752 width=192",
                             d_if.hcount, t_rise - t_fall);
                end
            end
            if (pv == 0 && d_if.vcount == 10'd1 && !got_vinc) begin
                got_vinc = 1;
                n_vec++;
                if (d_if.hcount !== 10'd0 || ph != 799 || d_if.bright !== 1'b1) begin
                    n_err++;
                    $display("FAIL line_wrap got h=%0d prev_h=%0d b=%b exp h=0 prev_h=799 b=1",
                             d_if.hcount, ph, d_if.bright);
                end
            end
            pb = d_if.bright; phs = d_if.hsync; ph = int'(d_if.hcount); pv = int'(d_if.vcount);
        end
        n_vec++;
        if (!got_bfall || t_rise < 0 || !got_vinc || fs_n != 1) begin
            n_err++;
            $display("FAIL hsweep_events got bfall=%0d hrise=%0d vinc=%0d fs_n=%0d exp 1 1 1 1",
                     got_bfall, t_rise >= 0, got_vinc, fs_n);
        end
    endtask

    task automatic test_vertical_small();
        int ph, pv, t_vfall, vs_w, last_fs, fs_n;
        logic pvs;
        hold_reset();
        release_reset();
        ph = S_HT - 1; pv = S_VT - 1; pvs = 1'b1;
        t_vfall = -1; vs_w = -1; last_fs = -1; fs_n = 0;
        for (int i = 1; i <= 2 * S_FRAME + 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (s_if.hcount > 10'(S_HT - 1) || s_if.vcount > 10'(S_VT - 1)) begin
                n_err++;
                $display("FAIL bounds clk=%0d got h=%0d v=%0d", i, s_if.hcount, s_if.vcount);
            end
            if (s_if.vcount >= 10'(S_VV)) begin
                n_vec++;
                if (s_if.bright !== 1'b0) begin
                    n_err++;
                    $display("FAIL vblank_bright clk=%0d v=%0d got=%b exp=0", i, s_if.vcount, s_if.bright);
                end
            end
            n_vec++;
            if (s_if.vsync !== !(s_if.vcount == 10'd12 || s_if.vcount == 10'd13)) begin
                n_err++;
                $display("FAIL vsync_window clk=%0d v=%0d got=%b", i, s_if.vcount, s_if.vsync);
            end
            if (pvs && !s_if.vsync && t_vfall < 0) t_vfall = i;
            if (!pvs && s_if.vsync && vs_w < 0 && t_vfall >= 0) begin
                vs_w = i - t_vfall;
                n_vec++;
                if (vs_w != S_VS * S_HT * S_DIV) begin
                    n_err++;
                    $display("FAIL vsync_width got=%0d exp=%0d", vs_w, S_VS * S_HT * S_DIV);
                end
            end
            if (s_if.frame_start === 1'b1) begin
                fs_n++;
                n_vec++;
                if (s_if.hcount !== 10'd0 || s_if.vcount !== 10'd0 || ph != S_HT - 1 || pv != S_VT - 1) begin
                    n_err++;
                    $display("FAIL frame_start_pos got h=%0d v=%0d prev=(%0d,%0d) exp 0 0 prev=(%0d,%0d)",
                             s_if.hcount, s_if.vcount, ph, pv, S_HT - 1, S_VT - 1);
                end
                if (last_fs >= 0) begin
                    n_vec++;
                    if (i - last_fs != S_FRAME) begin
                        n_err++;
                        $display("FAIL frame_gap got=%0d exp=%0d", i - last_fs, S_FRAME);
                    end
                end
                last_fs = i;
            end
            ph = int'(s_if.hcount); pv = int'(s_if.vcount); pvs = s_if.vsync;
        end
        n_vec++;
        if (fs_n != 3 || vs_w < 0) begin
            n_err++;
            $display("FAIL vertical_events got fs_n=%0d vs_seen=%0d exp fs_n=3 vs_seen=1", fs_n, vs_w >= 0);
        end
    endtask

    task automatic test_scoreboard_small();
        hold_reset();
        release_reset();
        model_init(1);
        sb_run(1, 2 * S_FRAME + 30, "sb_small");
    endtask

    task automatic test_mid_reset();
        int n;
        logic [24:0] got;
        hold_reset();
        release_reset();
        n = 0;
        while (d_if.hcount !== 10'd700 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n >= 2000 || d_if.hsync !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_reach_default got h=%0d hs=%b exp h=700 hs=0", d_if.hcount, d_if.hsync);
        end
        #2 rst_n = 1'b0;
        #1;
        got = sample(0);
        n_vec++;
        if (got !== {10'd799, 10'd524, 5'b01100}) begin
            n_err++;
            $display("FAIL mid_reset_async_default got=%h exp=%h", got, {10'd799, 10'd524, 5'b01100});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_init(0);
        sb_run(0, 40, "sb_restart_default");

        hold_reset();
        release_reset();
        n = 0;
        while (!(s_if.hcount === 10'd19 && s_if.vcount === 10'd13) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n >= 2000 || s_if.hsync !== 1'b0 || s_if.vsync !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_reach_small got h=%0d v=%0d hs=%b vs=%b exp 19 13 0 0",
                     s_if.hcount, s_if.vcount, s_if.hsync, s_if.vsync);
        end
        #2 rst_n = 1'b0;
        #1;
        got = sample(1);
        n_vec++;
        if (got !== {10'd22, 10'd16, 5'b01100}) begin
            n_err++;
            $display("FAIL mid_reset_async_small got=%h exp=%h", got, {10'd22, 10'd16, 5'b01100});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_init(1);
        sb_run(1, 60, "sb_restart_small");
    endtask

    task automatic test_div1();
        int last_h0, n_lines, t_fall, t_rise;
        logic phs;
        hold_reset();
        release_reset();
        last_h0 = -1; n_lines = 0; t_fall = -1; t_rise = -1; phs = 1'b1;
        for (int i = 1; i <= 1700; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (o_if.pix_tick !== 1'b1 || o_if.frame_start !== 1'(i == 1)) begin
                n_err++;
                $display("FAIL div1_tick clk=%0d got pt=%b fs=%b exp pt=1 fs=%b",
                         i, o_if.pix_tick, o_if.frame_start, 1'(i == 1));
            end
            if (o_if.hcount === 10'd0) begin
                if (last_h0 >= 0) begin
                    n_lines++;
                    n_vec++;
                    if (i - last_h0 != 800) begin
                        n_err++;
                        $display("FAIL div1_line got=%0d exp=800", i - last_h0);
                    end
                end
                last_h0 = i;
            end
            if (phs && !o_if.hsync && t_fall < 0) t_fall = i;
            if (!phs && o_if.hsync && t_rise < 0 && t_fall >= 0) begin
                t_rise = i;
                n_vec++;
                if (t_rise - t_fall != 96 || o_if.hcount !== 10'd752) begin
                    n_err++;
                    $display("FAIL div1_hsync got width=%0d h=%0d exp width=96 h=752",
                             t_rise - t_fall, o_if.hcount);
                end
            end
            phs = o_if.hsync;
        end
        n_vec++;
        if (n_lines != 2 || t_rise < 0) begin
            n_err++;
            $display("FAIL div1_events got lines=%0d hs_seen=%0d exp lines=2 hs_seen=1", n_lines, t_rise >= 0);
        end
    endtask

    initial begin
        test_reset();
        test_first_edges();
        test_scoreboard_default();
        test_hsweep();
        test_vertical_small();
        test_scoreboard_small();
        test_mid_reset();
        test_div1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
